// File: rtl/shift_register_pkg.sv
// Shared types for the parametrised shift register.
// Optional feature macro: SHIFTREG_DROP_CNT_EN (adds io_drop_cnt).
package shift_register_pkg;

  typedef enum logic [1:0] {SR_FWD, SR_REV, SR_CYC, SR_HOLD} sr_mode_e;

  // Per-stage next-state source
  typedef enum logic [1:0] {SEL_HOLD, SEL_PREV, SEL_NEXT, SEL_LAST} sr_sel_e;

  localparam int SR_DROP_CNT_W = 16;

endpackage

// File: rtl/shift_register_stage.sv
// One data+valid stage with a 4-way next-state mux (hold/prev/next/last).
module shift_register_stage
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  sr_sel_e          sel,
  input  logic [WIDTH-1:0] prev_data,
  input  logic             prev_vld,
  input  logic [WIDTH-1:0] next_data,
  input  logic             next_vld,
  input  logic [WIDTH-1:0] last_data,
  input  logic             last_vld,
  output logic [WIDTH-1:0] data,
  output logic             vld
);

  // Reset zeroes everything, clear drops only the valid bit, else follow sel
  always_ff @(posedge clock) begin
    if (reset) begin
      data <= '0;
      vld  <= 1'b0;
    end else if (clear) begin
      vld  <= 1'b0;
    end else begin
      case (sel)
        SEL_PREV: begin data <= prev_data; vld <= prev_vld; end
        SEL_NEXT: begin data <= next_data; vld <= next_vld; end
        SEL_LAST: begin data <= last_data; vld <= last_vld; end
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/shift_register_param.sv
// Parametrised shift register: FWD stream with ready/valid backpressure,
// REV drain, CYC segment rotate from a runtime tap, HOLD.
// Optional feature macro: SHIFTREG_DROP_CNT_EN (saturating discarded-word count).
module shift_register_param
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 15,
  parameter int TAP_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_enable,
  input  logic [1:0]               io_mode,
  input  logic [TAP_W-1:0]         io_tap,
  input  logic                     io_clear,
  input  logic                     io_in_valid,
  output logic                     io_in_ready,
  input  logic [WIDTH-1:0]         io_in_data,
  output logic                     io_out_valid,
  input  logic                     io_out_ready,
  output logic [WIDTH-1:0]         io_out_data,
  output logic [WIDTH*DEPTH-1:0]   io_stages,
`ifdef SHIFTREG_DROP_CNT_EN
  output logic [SR_DROP_CNT_W-1:0] io_drop_cnt,
`endif
  output logic [DEPTH-1:0]         io_stage_vld,
  output logic [CNT_W-1:0]         io_count
);

  logic [DEPTH-1:0][WIDTH-1:0] stg;
  logic [DEPTH-1:0]            vld;
  logic [CNT_W-1:0]            cnt_q;
  logic                        rst_q;
  sr_mode_e                    mode;
  logic step, step_fwd, step_rev, step_cyc, tap_ok;

  assign mode     = sr_mode_e'(io_mode);
  // rst_q keeps the pipe frozen (and not ready) for the cycle after reset
  assign step     = io_enable && !io_clear && !reset && !rst_q;
  assign tap_ok   = {1'b0, io_tap} < (TAP_W+1)'(DEPTH);
  assign step_fwd = step && (mode == SR_FWD) && (!vld[DEPTH-1] || io_out_ready);
  assign step_rev = step && (mode == SR_REV);
  assign step_cyc = step && (mode == SR_CYC) && tap_ok;

  assign io_in_ready  = step_fwd;
  assign io_out_valid = vld[DEPTH-1] && (mode == SR_FWD) && !reset && !rst_q;
  assign io_out_data  = stg[DEPTH-1];
  assign io_stages    = stg;
  assign io_stage_vld = vld;
  assign io_count     = cnt_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    sr_sel_e          sel;
    logic [WIDTH-1:0] prev_d, next_d;
    logic             prev_v, next_v;

    if (i == 0) begin : g_head
      assign prev_d = io_in_data;
      assign prev_v = io_in_valid;
    end else begin : g_mid_p
      assign prev_d = stg[i-1];
      assign prev_v = vld[i-1];
    end

    // Last stage refills with an empty zero word on REV
    if (i == DEPTH-1) begin : g_tail
      assign next_d = '0;
      assign next_v = 1'b0;
    end else begin : g_mid_n
      assign next_d = stg[i+1];
      assign next_v = vld[i+1];
    end

    // Pick this stage's source; CYC rotates only stages at or above the tap
    always_comb begin
      sel = SEL_HOLD;
      if (step_fwd)      sel = SEL_PREV;
      else if (step_rev) sel = SEL_NEXT;
      else if (step_cyc) begin
        if (io_tap == TAP_W'(i))     sel = SEL_LAST;
        else if (io_tap < TAP_W'(i)) sel = SEL_PREV;
      end
    end

    shift_register_stage #(.WIDTH(WIDTH)) u_stage (
      .clock     (clock),
      .reset     (reset),
      .clear     (io_clear),
      .sel       (sel),
      .prev_data (prev_d),
      .prev_vld  (prev_v),
      .next_data (next_d),
      .next_vld  (next_v),
      .last_data (stg[DEPTH-1]),
      .last_vld  (vld[DEPTH-1]),
      .data      (stg[i]),
      .vld       (vld[i])
    );
  end

  // Reset shadow flag
  always_ff @(posedge clock) rst_q <= reset;

  // Occupancy tracks the valid bits; a FWD step with a valid last stage always fires
  always_ff @(posedge clock) begin
    if (reset || io_clear) cnt_q <= '0;
    else if (step_fwd)     cnt_q <= cnt_q + CNT_W'(io_in_valid) - CNT_W'(vld[DEPTH-1]);
    else if (step_rev)     cnt_q <= cnt_q - CNT_W'(vld[0]);
  end

`ifdef SHIFTREG_DROP_CNT_EN
  logic [SR_DROP_CNT_W-1:0] drop_q;
  logic                     drop_ev;

  // step excludes io_clear, so at most one drop event per cycle
  assign drop_ev     = (io_clear && cnt_q != '0) || (step_rev && vld[0]);
  assign io_drop_cnt = drop_q;

  // Saturating count of discarded valid words
  always_ff @(posedge clock) begin
    if (reset)                        drop_q <= '0;
    else if (drop_ev && drop_q != '1) drop_q <= drop_q + 1'b1;
  end
`endif

endmodule

// File: tb/tb_shift_register_param.sv
// Directed bench for shift_register_param (DEPTH=15, WIDTH=128).
// Optional feature macro: SHIFTREG_DROP_CNT_EN (drop counter checks).
module tb_shift_register_param;
  localparam int W = 128;
  localparam int D = 15;

  logic           clock = 1'b0;
  logic           reset, io_enable, io_clear, io_in_valid, io_out_ready;
  logic [1:0]     io_mode;
  logic [3:0]     io_tap;
  logic [W-1:0]   io_in_data;
  logic           io_in_ready, io_out_valid;
  logic [W-1:0]   io_out_data;
  logic [W*D-1:0] io_stages;
  logic [D-1:0]   io_stage_vld;
  logic [3:0]     io_count;
`ifdef SHIFTREG_DROP_CNT_EN
  logic [15:0]    io_drop_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  shift_register_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_enable    (io_enable),
    .io_mode      (io_mode),
    .io_tap       (io_tap),
    .io_clear     (io_clear),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_data   (io_in_data),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_data  (io_out_data),
    .io_stages    (io_stages),
`ifdef SHIFTREG_DROP_CNT_EN
    .io_drop_cnt  (io_drop_cnt),
`endif
    .io_stage_vld (io_stage_vld),
    .io_count     (io_count)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] stg(input int i);
    return io_stages[i*W +: W];
  endfunction

  initial begin
    reset = 1'b1; io_enable = 1'b0; io_clear = 1'b0; io_in_valid = 1'b0;
    io_out_ready = 1'b0; io_mode = 2'd3; io_tap = '0; io_in_data = '0;
    tick(); tick();
    chk("rst_count", W'(io_count), '0);
    chk("rst_vld", W'(io_stage_vld), '0);
    chk("rst_stages_zero", W'(io_stages == '0), W'(1));
    chk("rst_in_ready", W'(io_in_ready), '0);

    // Cycle after reset: still not ready even with FWD enabled
    reset = 1'b0; io_enable = 1'b1; io_mode = 2'd0; io_out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", W'(io_in_ready), '0);
    chk("post_rst_out_valid", W'(io_out_valid), '0);
    tick();

    // FWD fill 1..15
    io_in_valid = 1'b1;
    for (int k = 1; k <= D; k++) begin
      io_in_data = W'(k);
      #1;
      if (k == 1) chk("fill_in_ready", W'(io_in_ready), W'(1));
      tick();
      if (k == D-1) chk("fill_out_valid_early", W'(io_out_valid), '0);
    end
    chk("fill_out_valid", W'(io_out_valid), W'(1));
    chk("fill_out_data", io_out_data, W'(1));
    chk("fill_count", W'(io_count), W'(15));

    // Continuous flow: word 1 fires, 16 enters
    io_in_data = W'(16);
    tick();
    chk("flow_out_data", io_out_data, W'(2));
    chk("flow_stage0", stg(0), W'(16));
    chk("flow_count", W'(io_count), W'(15));

    // Backpressure for 3 cycles
    io_out_ready = 1'b0; io_in_data = W'(100);
    #1;
    chk("bp_in_ready", W'(io_in_ready), '0);
    tick(); tick(); tick();
    chk("bp_stage0", stg(0), W'(16));
    chk("bp_stage14", stg(14), W'(2));
    chk("bp_count", W'(io_count), W'(15));
    chk("bp_out_valid", W'(io_out_valid), W'(1));
    io_out_ready = 1'b1;
    #1;
    chk("bp_release_ready", W'(io_in_ready), W'(1));
    tick();
    chk("bp_rel_stage0", stg(0), W'(100));
    chk("bp_rel_stage1", stg(1), W'(16));
    chk("bp_rel_stage14", stg(14), W'(3));

    // Load stage i = i+1, then one REV step
    for (int k = D; k >= 1; k--) begin
      io_in_data = W'(k);
      tick();
    end
    chk("rev_pre_stage0", stg(0), W'(1));
    chk("rev_pre_stage14", stg(14), W'(15));
    io_mode = 2'd1; io_in_valid = 1'b0;
    #1;
    chk("rev_in_ready", W'(io_in_ready), '0);
    chk("rev_out_valid", W'(io_out_valid), '0);
    tick();
    chk("rev_stage0", stg(0), W'(2));
    chk("rev_stage13", stg(13), W'(15));
    chk("rev_stage14", stg(14), '0);
    chk("rev_vld14", W'(io_stage_vld[14]), '0);
    chk("rev_count", W'(io_count), W'(14));
`ifdef SHIFTREG_DROP_CNT_EN
    chk("rev_drop", W'(io_drop_cnt), W'(1));
`endif

    // Load stage i = i for the rotate test
    io_mode = 2'd0; io_in_valid = 1'b1;
    for (int k = D-1; k >= 0; k--) begin
      io_in_data = W'(k);
      tick();
    end
    chk("cyc_pre_count", W'(io_count), W'(15));
    chk("cyc_pre_stage14", stg(14), W'(14));
    io_in_valid = 1'b0; io_mode = 2'd2; io_tap = 4'd4;
    #1;
    chk("cyc_in_ready", W'(io_in_ready), '0);
    tick();
    chk("cyc_stage4", stg(4), W'(14));
    chk("cyc_stage5", stg(5), W'(4));
    chk("cyc_stage14", stg(14), W'(13));
    chk("cyc_stage3", stg(3), W'(3));
    chk("cyc_stage0", stg(0), W'(0));
    chk("cyc_count", W'(io_count), W'(15));
    for (int k = 0; k < 10; k++) tick();
    chk("cyc_restore4", stg(4), W'(4));
    chk("cyc_restore10", stg(10), W'(10));
    chk("cyc_restore14", stg(14), W'(14));

    // Out-of-range tap and HOLD: no change
    io_tap = 4'd15;
    tick();
    chk("tap15_stage4", stg(4), W'(4));
    chk("tap15_stage14", stg(14), W'(14));
    io_mode = 2'd3;
    tick();
    chk("hold_stage5", stg(5), W'(5));
    chk("hold_count", W'(io_count), W'(15));

    // Six REV steps bring count to 9, stage i = i+6
    io_mode = 2'd1;
    for (int k = 0; k < 6; k++) tick();
    chk("rev6_count", W'(io_count), W'(9));
    chk("rev6_stage0", stg(0), W'(6));
    chk("rev6_vld", W'(io_stage_vld), W'(15'h01FF));
`ifdef SHIFTREG_DROP_CNT_EN
    chk("rev6_drop", W'(io_drop_cnt), W'(7));
`endif

    // Clear with count 9
    io_mode = 2'd0; io_clear = 1'b1; io_in_valid = 1'b1;
    #1;
    chk("clr_in_ready", W'(io_in_ready), '0);
    tick();
    io_clear = 1'b0;
    chk("clr_vld", W'(io_stage_vld), '0);
    chk("clr_count", W'(io_count), '0);
    chk("clr_stage0_held", stg(0), W'(6));
`ifdef SHIFTREG_DROP_CNT_EN
    chk("clr_drop", W'(io_drop_cnt), W'(8));
`endif

    // Fill with consumer stalled, then reset during the stall
    io_out_ready = 1'b0;
    for (int k = 0; k < D; k++) begin
      io_in_data = W'(200 + k);
      tick();
    end
    chk("stall_count", W'(io_count), W'(15));
    chk("stall_out_data", io_out_data, W'(200));
    chk("stall_in_ready", W'(io_in_ready), '0);
    reset = 1'b1;
    tick();
    chk("mid_rst_stages_zero", W'(io_stages == '0), W'(1));
    chk("mid_rst_vld", W'(io_stage_vld), '0);
    chk("mid_rst_count", W'(io_count), '0);
    chk("mid_rst_in_ready", W'(io_in_ready), '0);
    chk("mid_rst_out_valid", W'(io_out_valid), '0);
`ifdef SHIFTREG_DROP_CNT_EN
    chk("mid_rst_drop", W'(io_drop_cnt), '0);
`endif
    reset = 1'b0; io_out_ready = 1'b1;
    #1;
    chk("after_rst_in_ready", W'(io_in_ready), '0);
    chk("after_rst_out_valid", W'(io_out_valid), '0);
    tick();
    chk("after_rst_ready_back", W'(io_in_ready), W'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
